// File: rtl/ddr3_pkg.sv
// Shared types and constants for the DDR3 command arbiter.
// State encoding and native-interface command codes live here so the FSM and bench agree.
package ddr3_pkg;

  typedef enum logic [2:0] {
    StWaitInit = 3'd0,
    StIdle     = 3'd1,
    StCmd      = 3'd2,
    StWdata    = 3'd3,
    StRdata    = 3'd4
  } state_e;

  localparam logic [3:0] CMD_READ  = 4'b0001;
  localparam logic [3:0] CMD_WRITE = 4'b0010;
  localparam logic [3:0] CMD_NOP   = 4'b0000;

  localparam int unsigned TmoCntW   = 8;
  localparam logic [TmoCntW-1:0] TmoCntMax = '1;

  function automatic logic [3:0] cmd_code(input logic we);
    return we ? CMD_WRITE : CMD_READ;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker. Holds the last-served flag; the owner's FSM strobes
// update_i when a command is actually accepted, so aborted picks do not rotate priority.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req_i,
  input  logic       update_i,
  input  logic       served_i,
  output logic       valid_o,
  output logic       pick_o
);

  logic last_q, last_d;

  always_comb begin
    last_d = last_q;
    if (update_i) begin
      last_d = served_i;
    end
  end

  // Last-served resets to 1 so port 0 wins the first tie.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      last_q <= 1'b1;
    end else begin
      last_q <= last_d;
    end
  end

  always_comb begin
    valid_o = |req_i;
    case (req_i)
      2'b01:   pick_o = 1'b0;
      2'b10:   pick_o = 1'b1;
      2'b11:   pick_o = ~last_q;
      default: pick_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/ddr3_cmd_arb.sv
// Two-port round-robin command arbiter in front of a DDR3 controller's native command port.
// One transaction in flight; read beats go back to their owner or are aborted on timeout.
module ddr3_cmd_arb
  import ddr3_pkg::*;
#(
  parameter int unsigned ADDR_W     = 26,
  parameter int unsigned DATA_W     = 64,
  parameter logic [7:0]  RD_TIMEOUT = 8'hFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              init_done,
  input  logic              req0_valid,
  input  logic              req0_we,
  input  logic [ADDR_W-1:0] req0_addr,
  input  logic [DATA_W-1:0] req0_wdata,
  input  logic              req1_valid,
  input  logic              req1_we,
  input  logic [ADDR_W-1:0] req1_addr,
  input  logic [DATA_W-1:0] req1_wdata,
  output logic              req0_grant,
  output logic              req1_grant,
  output logic              req0_done,
  output logic              req1_done,
  output logic [DATA_W-1:0] rdata,
  output logic              rd_err,
  output logic              cmd_valid,
  output logic [3:0]        cmd,
  output logic [ADDR_W-1:0] cmd_addr,
  input  logic              cmd_rdy,
  input  logic              datain_rdy,
  output logic [DATA_W-1:0] write_data,
  input  logic [DATA_W-1:0] read_data,
  input  logic              read_data_valid
);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [TmoCntW-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;
  logic [1:0]          grant_q, grant_d;
  logic [1:0]          done_q, done_d;
  logic                rd_err_q, rd_err_d;

  logic                arb_valid;
  logic                arb_pick;
  logic                arb_update;
  logic                cmd_accept;
  logic                rd_timeout;

  assign cmd_accept = (state_q == StCmd) && cmd_rdy && init_done;
  assign arb_update = cmd_accept;

  // Fires on the cycle RDATA has been occupied for RD_TIMEOUT cycles.
  assign rd_timeout = ({1'b0, cnt_q} + 9'd1) >= {1'b0, RD_TIMEOUT};

  rr_arb2 u_rr_arb2 (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    ({req1_valid, req0_valid}),
    .update_i (arb_update),
    .served_i (owner_q),
    .valid_o  (arb_valid),
    .pick_o   (arb_pick)
  );

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StWaitInit;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; losing init_done aborts from any state.
  always_comb begin
    state_d = state_q;
    if (!init_done) begin
      state_d = StWaitInit;
    end else begin
      case (state_q)
        StWaitInit: state_d = StIdle;
        StIdle: begin
          if (arb_valid) begin
            state_d = StCmd;
          end
        end
        StCmd: begin
          if (cmd_rdy) begin
            state_d = we_q ? StWdata : StRdata;
          end
        end
        StWdata: begin
          if (datain_rdy) begin
            state_d = StIdle;
          end
        end
        StRdata: begin
          if (read_data_valid || rd_timeout) begin
            state_d = StIdle;
          end
        end
        default: state_d = StWaitInit;
      endcase
    end
  end

  // Request latch, timeout counter, read capture and completion pulses.
  always_comb begin
    owner_d  = owner_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    cnt_d    = cnt_q;
    rdata_d  = rdata_q;
    grant_d  = 2'b00;
    done_d   = 2'b00;
    rd_err_d = 1'b0;
    if (!init_done) begin
      rdata_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (arb_valid) begin
            owner_d = arb_pick;
            we_d    = arb_pick ? req1_we : req0_we;
            addr_d  = arb_pick ? req1_addr : req0_addr;
            wdata_d = arb_pick ? req1_wdata : req0_wdata;
          end
        end
        StCmd: begin
          if (cmd_rdy) begin
            grant_d[owner_q] = 1'b1;
            cnt_d            = '0;
          end
        end
        StWdata: begin
          if (datain_rdy) begin
            done_d[owner_q] = 1'b1;
          end
        end
        StRdata: begin
          // Data beats the timeout when both land on the same cycle.
          if (read_data_valid) begin
            rdata_d         = read_data;
            done_d[owner_q] = 1'b1;
          end else if (rd_timeout) begin
            rd_err_d = 1'b1;
          end else if (cnt_q != TmoCntMax) begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_q  <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      cnt_q    <= '0;
      rdata_q  <= '0;
      grant_q  <= 2'b00;
      done_q   <= 2'b00;
      rd_err_q <= 1'b0;
    end else begin
      owner_q  <= owner_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      grant_q  <= grant_d;
      done_q   <= done_d;
      rd_err_q <= rd_err_d;
    end
  end

  // Output decode from the registered state and latches.
  always_comb begin
    cmd_valid  = 1'b0;
    cmd        = CMD_NOP;
    cmd_addr   = '0;
    write_data = '0;
    case (state_q)
      StCmd: begin
        cmd_valid = 1'b1;
        cmd       = cmd_code(we_q);
        cmd_addr  = addr_q;
      end
      StWdata: write_data = wdata_q;
      default: ;
    endcase
  end

  assign req0_grant = grant_q[0];
  assign req1_grant = grant_q[1];
  assign req0_done  = done_q[0];
  assign req1_done  = done_q[1];
  assign rdata      = rdata_q;
  assign rd_err     = rd_err_q;

endmodule

// File: tb/tb_ddr3_cmd_arb.sv
// Self-checking bench for ddr3_cmd_arb: directed bring-up, randomized transactions,
// timeout corners and aborts, checked against a transaction-level model of the arbiter.
module tb_ddr3_cmd_arb;

  localparam int AW = 26;
  localparam int DW = 64;
  localparam int T  = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          req0_valid = 1'b0, req1_valid = 1'b0;
  logic          req0_we = 1'b0, req1_we = 1'b0;
  logic [AW-1:0] req0_addr = '0, req1_addr = '0;
  logic [DW-1:0] req0_wdata = '0, req1_wdata = '0;
  logic          req0_grant, req1_grant, req0_done, req1_done;
  logic [DW-1:0] rdata;
  logic          rd_err;
  logic          cmd_valid;
  logic [3:0]    cmd;
  logic [AW-1:0] cmd_addr;
  logic          cmd_rdy = 1'b0;
  logic          datain_rdy = 1'b0;
  logic [DW-1:0] write_data;
  logic [DW-1:0] read_data = '0;
  logic          read_data_valid = 1'b0;

  logic [4:0]    pulses;
  assign pulses = {req0_grant, req1_grant, req0_done, req1_done, rd_err};

  always #5 clk = ~clk;

  ddr3_cmd_arb #(
    .ADDR_W     (AW),
    .DATA_W     (DW),
    .RD_TIMEOUT (8'h10)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .init_done       (init_done),
    .req0_valid      (req0_valid),
    .req0_we         (req0_we),
    .req0_addr       (req0_addr),
    .req0_wdata      (req0_wdata),
    .req1_valid      (req1_valid),
    .req1_we         (req1_we),
    .req1_addr       (req1_addr),
    .req1_wdata      (req1_wdata),
    .req0_grant      (req0_grant),
    .req1_grant      (req1_grant),
    .req0_done       (req0_done),
    .req1_done       (req1_done),
    .rdata           (rdata),
    .rd_err          (rd_err),
    .cmd_valid       (cmd_valid),
    .cmd             (cmd),
    .cmd_addr        (cmd_addr),
    .cmd_rdy         (cmd_rdy),
    .datain_rdy      (datain_rdy),
    .write_data      (write_data),
    .read_data       (read_data),
    .read_data_valid (read_data_valid)
  );

  int            n_cmp = 0;
  int            n_fail = 0;
  bit            pend [2];
  bit            we_m [2];
  logic [AW-1:0] addr_m [2];
  logic [DW-1:0] wd_m [2];
  int            last_srv = 1;
  logic [DW-1:0] last_rdata = '0;

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_quiet(input string tag);
    check({tag, "_ctl"}, 64'({cmd_valid, cmd, cmd_addr, pulses}), 64'd0);
    check({tag, "_wdata"}, write_data, 64'd0);
    check({tag, "_rdata"}, rdata, 64'd0);
  endtask

  function automatic int pick(input bit p0, input bit p1, input int last);
    if (p0 && p1) return (last == 0) ? 1 : 0;
    return p0 ? 0 : 1;
  endfunction

  function automatic logic [4:0] gnt_vec(input int w);
    return (w == 0) ? 5'b10000 : 5'b01000;
  endfunction

  function automatic logic [4:0] done_vec(input int w);
    return (w == 0) ? 5'b00100 : 5'b00010;
  endfunction

  task automatic new_req(input int p);
    pend[p]   = 1'b1;
    we_m[p]   = 1'($urandom_range(0, 1));
    addr_m[p] = 26'($urandom);
    wd_m[p]   = {$urandom, $urandom};
  endtask

  task automatic drive_reqs();
    req0_valid = pend[0];
    req0_we    = we_m[0];
    req0_addr  = addr_m[0];
    req0_wdata = wd_m[0];
    req1_valid = pend[1];
    req1_we    = we_m[1];
    req1_addr  = addr_m[1];
    req1_wdata = wd_m[1];
  endtask

  // Called with the DUT idle; returns after the grant pulse has been checked.
  // mode: 0 random, 1 both ports reading, 2 force write, 3 force read.
  task automatic start_txn(input int mode, output int w);
    int d;
    for (int p = 0; p < 2; p++) begin
      if (!pend[p] && (mode == 1 || $urandom_range(0, 1) == 1)) new_req(p);
    end
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    if (mode != 0) begin
      for (int p = 0; p < 2; p++) if (pend[p]) we_m[p] = (mode == 2);
    end
    drive_reqs();
    read_data_valid = ($urandom_range(0, 2) == 0);
    read_data       = {$urandom, $urandom};
    w = pick(pend[0], pend[1], last_srv);
    step();
    read_data_valid = 1'b0;
    check("cmd_valid_rise", 64'(cmd_valid), 64'd1);
    check("cmd_code", 64'(cmd), we_m[w] ? 64'd2 : 64'd1);
    check("cmd_addr", 64'(cmd_addr), 64'(addr_m[w]));
    check("idle_pulses", 64'(pulses), 64'd0);
    check("rdata_hold", rdata, last_rdata);
    d = int'($urandom_range(0, 3));
    for (int i = 0; i <= d; i++) begin
      cmd_rdy = (i == d);
      step();
      if (i < d) check("cmd_wait", 64'({cmd_valid, pulses}), 64'({1'b1, 5'b0}));
    end
    check("grant", 64'(pulses), 64'(gnt_vec(w)));
    check("cmd_drop", 64'({cmd_valid, cmd}), 64'd0);
    cmd_rdy  = 1'b0;
    pend[w]  = 1'b0;
    last_srv = w;
    if (!pend[1-w] && $urandom_range(0, 2) == 0) new_req(1 - w);
    drive_reqs();
  endtask

  // fixed_k > 0 sets the edge (counted from acceptance) carrying read_data_valid.
  task automatic finish_txn(input int w, input int fixed_k);
    int d, k;
    logic [DW-1:0] rd;
    if (we_m[w]) begin
      d = int'($urandom_range(0, 3));
      for (int i = 0; i <= d; i++) begin
        check("write_data", write_data, wd_m[w]);
        datain_rdy = (i == d);
        step();
        if (i < d) check("wdata_wait", 64'(pulses), 64'd0);
      end
      check("write_done", 64'(pulses), 64'(done_vec(w)));
      datain_rdy = 1'b0;
    end else begin
      k  = (fixed_k > 0) ? fixed_k : int'($urandom_range(1, T + 3));
      rd = {$urandom, $urandom};
      for (int i = 1; i <= T; i++) begin
        read_data_valid = (i == k);
        read_data       = (i == k) ? rd : {$urandom, $urandom};
        step();
        if (i == k) begin
          check("read_done", 64'(pulses), 64'(done_vec(w)));
          check("read_rdata", rdata, rd);
          last_rdata = rd;
          break;
        end
        if (i == T) begin
          check("read_timeout", 64'(pulses), 64'd1);
          break;
        end
        check("read_wait", 64'(pulses), 64'd0);
      end
      read_data_valid = 1'b0;
    end
  endtask

  task automatic txn(input int mode, input int fixed_k);
    int w;
    start_txn(mode, w);
    finish_txn(w, fixed_k);
  endtask

  initial begin
    int  w;
    bit  seen;
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;

    // Bring-up: request held while init_done is low, then the directed write.
    pend[0]   = 1'b1;
    we_m[0]   = 1'b1;
    addr_m[0] = 26'h0000100;
    wd_m[0]   = 64'hDEADBEEF_00000001;
    drive_reqs();
    cmd_rdy    = 1'b1;
    datain_rdy = 1'b1;
    seen = 1'b0;
    repeat (100) begin
      step();
      seen |= cmd_valid;
    end
    check("init_hold", 64'(seen), 64'd0);
    init_done = 1'b1;
    step();
    check("init_plus1", 64'(cmd_valid), 64'd0);
    step();
    check("init_plus2", 64'({cmd_valid, cmd, cmd_addr}), 64'({1'b1, 4'b0010, 26'h0000100}));
    check("init_plus2_pulses", 64'(pulses), 64'd0);
    step();
    check("dir_grant", 64'({pulses, cmd_valid}), 64'({5'b10000, 1'b0}));
    check("dir_wdata", write_data, 64'hDEADBEEF_00000001);
    pend[0] = 1'b0;
    drive_reqs();
    cmd_rdy = 1'b0;
    step();
    check("dir_done", 64'(pulses), 64'(5'b00100));
    datain_rdy = 1'b0;
    last_srv   = 0;

    repeat (12) txn(0, 0);
    repeat (6) txn(1, 5);
    txn(3, T + 3);
    txn(0, 0);
    txn(3, T);

    // Reset in the middle of a write beat.
    start_txn(2, w);
    check("pre_rst_wdata", write_data, wd_m[w]);
    rst = 1'b1;
    #1;
    check_quiet("rst_async");
    @(negedge clk);
    check_quiet("rst_hold");
    rst        = 1'b0;
    datain_rdy = 1'b1;
    last_srv   = 1;
    last_rdata = '0;
    step();
    check("rst_no_done", 64'({cmd_valid, pulses}), 64'd0);
    datain_rdy = 1'b0;
    txn(0, 0);

    // init_done lost while waiting for a read beat.
    start_txn(3, w);
    init_done       = 1'b0;
    read_data_valid = 1'b1;
    read_data       = {$urandom, $urandom};
    step();
    check_quiet("init_drop");
    read_data_valid = 1'b0;
    last_rdata      = '0;
    if (!pend[1-w]) new_req(1 - w);
    drive_reqs();
    repeat (4) begin
      step();
      check("init_low_idle", 64'({cmd_valid, pulses}), 64'd0);
    end
    init_done = 1'b1;
    step();
    check("init_back", 64'(cmd_valid), 64'd0);

    repeat (12) txn(0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed no summary expected finish within 20000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/ddr3_cmd_arb.md
# ddr3_cmd_arb

Two-port command arbiter between user logic and the DDR3 memory controller core's native command interface. It stays idle until the core reports init_done, the signal that closes the power-up/calibration sequence. It then grants the single command channel round-robin to two requesters and keeps one transaction in flight at a time. For each read it returns the data beat to the owning requester and enforces a read-return timeout.

## Interface
- ADDR_W, 26: DDR address width
- DATA_W, 64: data beat width; one beat per command
- RD_TIMEOUT, 8'hFF: cycles to wait for read_data_valid before abort
- clk  in  1  system clock, single domain; reset is asynchronous and active-high
- rst  in  1  asynchronous, active-high reset
- init_done  in  1  DDR core initialised; arbitration disabled while low
- req0_valid, req1_valid  in  1  request pending; held until grant
- req0_we, req1_we  in  1  1 = write, 0 = read
- req0_addr, req1_addr  in  ADDR_W  command address
- req0_wdata, req1_wdata  in  DATA_W  write data; must be stable until done
- req0_grant, req1_grant  out  1  one-cycle pulse: command accepted by core
- req0_done, req1_done  out  1  one-cycle pulse: write beat sent / read beat returned
- rdata  out  DATA_W  registered read data, valid with reqN_done of a read
- rd_err  out  1  one-cycle pulse on read timeout
- cmd_valid  out  1  command strobe to core
- cmd  out  4  4'b0001 READ, 4'b0010 WRITE, 4'b0000 otherwise
- cmd_addr  out  ADDR_W  registered address
- cmd_rdy  in  1  core accepts command when cmd_valid & cmd_rdy
- datain_rdy  in  1  core ready for write beat
- write_data  out  DATA_W  write beat
- read_data  in  DATA_W  read beat
- read_data_valid  in  1  read beat strobe

## Operation
- States: WAIT_INIT, IDLE, CMD, WDATA, RDATA.
- WAIT_INIT: leave when init_done = 1, go to IDLE.
- IDLE:
  - If any reqN_valid, pick the owner, latch owner id, we, addr and wdata, then go to CMD.
  - Arbitration: with one request pending it wins. With both pending, the port not served last wins. The last-served bit resets to 1, so port 0 wins the first tie.
- CMD: cmd_valid = 1 with cmd/cmd_addr from the latch.
  - On cmd_rdy: pulse owner grant and clear cmd_valid.
  - Then go to WDATA if we = 1, else RDATA.
  - Update the last-served bit.
- WDATA: write_data = latched wdata.
  - On datain_rdy: pulse owner done and go to IDLE.
- RDATA: timeout counter counts up from 0.
  - On read_data_valid: capture rdata, pulse owner done, go to IDLE.
  - If the counter reaches RD_TIMEOUT first: pulse rd_err, no done, go to IDLE.
  - If read_data_valid and timeout occur in the same cycle, data wins and rd_err stays 0.
- init_done falling in any state forces WAIT_INIT on the next cycle, aborts the transaction and issues no done.
- Requests arriving while busy wait; they are never dropped.
- Stray read_data_valid outside RDATA is ignored.

## Timing
- Reset: state WAIT_INIT, last-served = 1, counter 0, all outputs 0 (cmd = 4'b0000, cmd_addr = 0, rdata = 0).
- Reset mid-transaction: immediate, with no completion pulses.
- Request seen in IDLE at edge N: cmd_valid high from N+1.
- Grant pulse coincides with the cmd_rdy cycle (registered, visible the cycle after acceptance edge); cmd_valid is low the cycle after acceptance.
- Minimum write turnaround, with cmd_rdy and datain_rdy already high: IDLE → CMD → WDATA → IDLE, 3 cycles per transaction.
- rdata and done become valid together, 1 cycle after read_data_valid.
- Timeout counter is 8 bits and saturates; it is cleared on entry to RDATA.

## Structure
- Shared package ddr3_pkg:
  - state encoding (3 bits: WAIT_INIT=0, IDLE=1, CMD=2, WDATA=3, RDATA=4)
  - CMD_READ/CMD_WRITE/CMD_NOP constants
- Sub-module rr_arb2: two-requester round-robin picker holding the last-served flop, with an update strobe from the FSM.
- The FSM, latches and timeout counter stay in the top module.

## Test plan
- init_done held 0 for 100 cycles with req0_valid = 1 → cmd_valid stays 0; init_done = 1 → cmd_valid rises 2 cycles later.
- req0 write, addr 26'h0000100, wdata 64'hDEADBEEF_00000001; cmd_rdy and datain_rdy stuck high → cmd = 4'b0010, req0_grant then req0_done, write_data matches.
- req0 and req1 both reading continuously, with read_data_valid returned 5 cycles after grant → grants alternate 0,1,0,1, and each done goes to the correct port with the matching rdata.
- Read issued, read_data_valid never asserted, RD_TIMEOUT = 8'h10 → rd_err pulses exactly once 16 cycles after entering RDATA; no done; next request served.
- read_data_valid on the same cycle as timeout → done = 1, rd_err = 0.
- Assert rst during WDATA, and separately drop init_done during RDATA → all outputs 0, no done pulse, return to WAIT_INIT; resumes after init_done.
